// File: rtl/tick_stopwatch.sv
// Tick-driven MM:SS stopwatch with start/stop/clear control and BCD digit outputs.
// Optional display-freeze (lap) feature is enabled by defining LAP_EN.
module tick_stopwatch #(
    parameter int unsigned TICKS_PER_SEC = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] bcd,
    output logic        running,
    output logic        wrap
);

    localparam int unsigned PreW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    state_e          state_q, state_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [3:0]      sec_ones_q, sec_ones_d;
    logic [3:0]      sec_tens_q, sec_tens_d;
    logic [3:0]      min_ones_q, min_ones_d;
    logic [3:0]      min_tens_q, min_tens_d;
    logic            hold_q, hold_d;
    logic            wrap_d;
    logic            counted;

`ifdef LAP_EN
    always_comb begin
        hold_d = hold_q;
        if (clear) begin
            hold_d = 1'b0;
        end else if (lap && state_q != StIdle) begin
            hold_d = ~hold_q;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign hold_d     = 1'b0;
`endif

    assign counted = (state_q == StRun) && tick && !clear;

    // Command decode: clear > stop > start; stop outside RUN swallows start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else if (stop) begin
            if (state_q == StRun) state_d = StPause;
        end else if (start) begin
            if (state_q != StRun) state_d = StRun;
        end
    end

    always_comb begin
        pre_d      = pre_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (clear) begin
            pre_d      = '0;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else if (counted) begin
            if (pre_q == PreMax) begin
                pre_d = '0;
                if (sec_ones_q == 4'd9) begin
                    sec_ones_d = 4'd0;
                    if (sec_tens_q == 4'd5) begin
                        sec_tens_d = 4'd0;
                        if (min_ones_q == 4'd9) begin
                            min_ones_d = 4'd0;
                            if (min_tens_q == 4'd5) begin
                                min_tens_d = 4'd0;
                                wrap_d     = 1'b1;
                            end else begin
                                min_tens_d = min_tens_q + 4'd1;
                            end
                        end else begin
                            min_ones_d = min_ones_q + 4'd1;
                        end
                    end else begin
                        sec_tens_d = sec_tens_q + 4'd1;
                    end
                end else begin
                    sec_ones_d = sec_ones_q + 4'd1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pre_q      <= '0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            hold_q     <= 1'b0;
            bcd        <= 16'h0000;
            running    <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            hold_q     <= hold_d;
            running    <= (state_d == StRun);
            wrap       <= wrap_d;
            // bcd already equals the live digits, so simply not loading it freezes them.
            if (!hold_d) begin
                bcd <= {min_tens_d, min_ones_d, sec_tens_d, sec_ones_d};
            end
        end
    end

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed self-checking bench for tick_stopwatch (TICKS_PER_SEC=2).
// Exercises the lap freeze when LAP_EN is defined, lap-ignored otherwise.
module tb_tick_stopwatch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] bcd;
    logic        running;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    int wrap_cnt;

    tick_stopwatch #(.TICKS_PER_SEC(2)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
        .lap    (lap),
        .bcd    (bcd),
        .running(running),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; returns at the following negedge.
    task automatic step(input logic t, input logic st, input logic sp, input logic cl,
                        input logic lp);
        tick = t; start = st; stop = sp; clear = cl; lap = lp;
        @(negedge clk);
        tick = 0; start = 0; stop = 0; clear = 0; lap = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_bcd", bcd, 16'h0000);
        chk("reset_running", running, 1'b0);
        chk("reset_wrap", wrap, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // start with a coincident tick: tick ignored
        step(1, 1, 0, 0, 0);
        chk("start_running", running, 1'b1);
        chk("start_tick_ignored", bcd, 16'h0000);
        ticks(20);
        chk("twenty_ticks", bcd, 16'h0010);

        step(0, 0, 0, 1, 0);
        chk("clear_bcd", bcd, 16'h0000);
        chk("clear_running", running, 1'b0);

        // reach 00:05 with prescaler at 1, pause, then resume
        step(0, 1, 0, 0, 0);
        ticks(11);
        chk("at_0005", bcd, 16'h0005);
        step(0, 0, 1, 0, 0);
        chk("stop_running", running, 1'b0);
        ticks(10);
        chk("pause_holds", bcd, 16'h0005);
        step(0, 1, 0, 0, 0);
        chk("resume_running", running, 1'b1);
        ticks(1);
        chk("prescaler_kept", bcd, 16'h0006);

        // stop together with a tick: tick counted, then PAUSE
        ticks(1);
        chk("pre_one", bcd, 16'h0006);
        step(1, 0, 1, 0, 0);
        chk("stop_tick_counted", bcd, 16'h0007);
        chk("stop_tick_paused", running, 1'b0);

        // clear+stop+start+tick in RUN
        step(0, 1, 0, 0, 0);
        ticks(3);
        chk("before_clear_all", bcd, 16'h0008);
        step(1, 1, 1, 1, 0);
        chk("clear_all_bcd", bcd, 16'h0000);
        chk("clear_all_running", running, 1'b0);
        ticks(4);
        chk("idle_ignores_ticks", bcd, 16'h0000);

        // async reset mid-count at 00:37
        step(0, 1, 0, 0, 0);
        ticks(74);
        chk("at_0037", bcd, 16'h0037);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_bcd", bcd, 16'h0000);
        chk("async_reset_running", running, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // run to 59:58, then roll over
        step(0, 1, 0, 0, 0);
        wrap_cnt = 0;
        for (int i = 0; i < 7196; i++) begin
            step(1, 0, 0, 0, 0);
            if (wrap) wrap_cnt++;
        end
        chk("at_5958", bcd, 16'h5958);
        chk("no_early_wrap", wrap_cnt, 0);
        ticks(2);
        chk("at_5959", bcd, 16'h5959);
        chk("wrap_low_5959", wrap, 1'b0);
        ticks(2);
        chk("rollover_bcd", bcd, 16'h0000);
        chk("rollover_wrap", wrap, 1'b1);
        step(0, 0, 0, 0, 0);
        chk("wrap_one_cycle", wrap, 1'b0);
        chk("run_after_wrap", running, 1'b1);
        ticks(2);
        chk("count_after_wrap", bcd, 16'h0001);

        // lap behaviour
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        ticks(24);
        chk("at_0012", bcd, 16'h0012);
        step(0, 0, 0, 0, 1);
`ifdef LAP_EN
        ticks(6);
        chk("lap_frozen", bcd, 16'h0012);
        chk("lap_still_running", running, 1'b1);
        step(0, 0, 0, 0, 1);
        chk("lap_release", bcd, 16'h0015);
        ticks(2);
        chk("lap_live_again", bcd, 16'h0016);
`else
        ticks(6);
        chk("lap_ignored", bcd, 16'h0015);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
